// File: rtl/musicrom_arb_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musicrom_arb_pkg: shared types and constants for the music-ROM   |
// | arbiter.                                        Revision: 1.0    |
// +------------------------------------------------------------------+
package musicrom_arb_pkg;

  localparam int ARB_IDW         = 3;
  localparam int ROM_WIDTH_DEF   = 17;
  localparam int ROM_LATENCY_DEF = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_ACK     = 2'd3
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/musicrom_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musicrom_arbiter_if: requester handshake plus ROM port bundle.   |
// |                                                 Revision: 1.0    |
// +------------------------------------------------------------------+
interface musicrom_arbiter_if
  import musicrom_arb_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int ROM_WIDTH = ROM_WIDTH_DEF
);

  logic [NREQ-1:0]           req;
  logic [NREQ*ROM_WIDTH-1:0] req_addr;
  logic [NREQ-1:0]           ack;
  logic [7:0]                rdata;
  logic [ARB_IDW-1:0]        grant_id;
  logic                      busy;
  logic [ROM_WIDTH-1:0]      musicrom_addr;
  logic [7:0]                musicrom_data_out;

  modport slave (
    input  req, req_addr, musicrom_data_out,
    output ack, rdata, grant_id, busy, musicrom_addr
  );

  modport master (
    output req, req_addr, musicrom_data_out,
    input  ack, rdata, grant_id, busy, musicrom_addr
  );

endinterface
`default_nettype wire

// File: rtl/musicrom_rr_pick.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musicrom_rr_pick: combinational round-robin winner search from   |
// | rr_ptr upward, wrapping at NREQ-1.               Revision: 1.0   |
// +------------------------------------------------------------------+
module musicrom_rr_pick
  import musicrom_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]    req,
  input  logic [ARB_IDW-1:0] rr_ptr,
  output logic [ARB_IDW-1:0] winner,
  output logic               any
);

  logic [2*NREQ-1:0] w_rot;
  int                w_idx;

  // Doubling the vector turns the wrap-around search into a plain shift.
  always_comb begin
    w_rot  = {req, req} >> rr_ptr;
    winner = '0;
    any    = 1'b0;
    w_idx  = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && w_rot[k]) begin
        w_idx = int'(rr_ptr) + k;
        if (w_idx >= NREQ) w_idx = w_idx - NREQ;
        winner = w_idx[ARB_IDW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/musicrom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | musicrom_arbiter: shares the synchronous music ROM among NREQ    |
// | requesters; optional MUSICROM_ARB_PRIO0_EN gives requester 0     |
// | fixed priority.                                  Revision: 1.0   |
// +------------------------------------------------------------------+
module musicrom_arbiter
  import musicrom_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ROM_WIDTH   = ROM_WIDTH_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  musicrom_arbiter_if.slave  bus
);

  localparam logic [ARB_IDW-1:0] c_last_id = ARB_IDW'(NREQ - 1);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  logic [2:0]           r_cnt;
  logic [ARB_IDW-1:0]   r_rr_ptr;
  logic [ARB_IDW-1:0]   r_grant_id;
  logic [ROM_WIDTH-1:0] r_addr;
  logic [7:0]           r_rdata;
  logic [NREQ-1:0]      r_ack;
  logic                 r_busy;

  logic [NREQ-1:0]      w_pick_req;
  logic [ARB_IDW-1:0]   w_pick_winner;
  logic                 w_pick_any;
  logic [ARB_IDW-1:0]   w_winner;
  logic                 w_any;
  logic                 w_ptr_upd;
  logic [ARB_IDW-1:0]   w_ptr_nxt;
  logic [ROM_WIDTH-1:0] w_grant_addr;
  logic [NREQ-1:0]      w_ack_onehot;

`ifdef MUSICROM_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation and leaves the pointer untouched.
  assign w_pick_req = {bus.req[NREQ-1:1], 1'b0};
  assign w_winner   = bus.req[0] ? '0 : w_pick_winner;
  assign w_any      = w_pick_any | bus.req[0];
  assign w_ptr_upd  = ~bus.req[0];
`else
  assign w_pick_req = bus.req;
  assign w_winner   = w_pick_winner;
  assign w_any      = w_pick_any;
  assign w_ptr_upd  = 1'b1;
`endif

  musicrom_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (w_pick_req),
    .rr_ptr (r_rr_ptr),
    .winner (w_pick_winner),
    .any    (w_pick_any)
  );

  assign w_ptr_nxt = (w_winner == c_last_id) ? '0 : w_winner + 1'b1;

  always_comb begin
    w_grant_addr = '0;
    w_ack_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_winner == ARB_IDW'(i)) w_grant_addr = bus.req_addr[i*ROM_WIDTH +: ROM_WIDTH];
      if (r_grant_id == ARB_IDW'(i)) w_ack_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_any) w_state_nxt = ST_WAIT;
      ST_WAIT:    if (r_cnt == 3'd1) w_state_nxt = ST_CAPTURE;
      ST_CAPTURE: w_state_nxt = ST_ACK;
      ST_ACK:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_addr     <= '0;
      r_rdata    <= '0;
      r_ack      <= '0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_addr     <= w_grant_addr;
            r_grant_id <= w_winner;
            r_cnt      <= 3'(ROM_LATENCY);
            r_busy     <= 1'b1;
            if (w_ptr_upd) r_rr_ptr <= w_ptr_nxt;
          end
        end
        ST_WAIT:    r_cnt <= r_cnt - 3'd1;
        ST_CAPTURE: begin
          r_rdata <= bus.musicrom_data_out;
          r_ack   <= w_ack_onehot;
        end
        ST_ACK: begin
          r_ack  <= '0;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack           = r_ack;
  assign bus.rdata         = r_rdata;
  assign bus.grant_id      = r_grant_id;
  assign bus.busy          = r_busy;
  assign bus.musicrom_addr = r_addr;

endmodule
`default_nettype wire

// File: tb/tb_musicrom_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_musicrom_arbiter: directed bench, latency-1 and latency-3     |
// | instances sharing clk/rst_n.                     Revision: 1.0   |
// +------------------------------------------------------------------+
module tb_musicrom_arbiter;

  localparam int RW = 17;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  musicrom_arbiter_if #(.NREQ(3), .ROM_WIDTH(RW)) if1 ();
  musicrom_arbiter_if #(.NREQ(3), .ROM_WIDTH(RW)) if3 ();

  musicrom_arbiter #(.NREQ(3), .ROM_WIDTH(RW), .ROM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  musicrom_arbiter #(.NREQ(3), .ROM_WIDTH(RW), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  function automatic logic [7:0] rom_f(input logic [RW-1:0] a);
    return a[7:0] ^ 8'h16 ^ a[16:9];
  endfunction

  // ROM models: one and three register stages of read latency
  logic [7:0] r_p1, r_p2;
  always @(posedge clk) begin
    if1.musicrom_data_out <= rom_f(if1.musicrom_addr);
    r_p1                  <= rom_f(if3.musicrom_addr);
    r_p2                  <= r_p1;
    if3.musicrom_data_out <= r_p2;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [2:0]  exp_id;
  logic [2:0]  seen_ack;
  logic [RW-1:0] a0, a1, a2;

  initial begin
    n_pass = 0; n_total = 0;
    rst_n = 1'b0;
    if1.req = '0; if1.req_addr = '0;
    if3.req = '0; if3.req_addr = '0;
    a0 = 17'h00100; a1 = 17'h00201; a2 = 17'h00302;
    tick(2);
    chk("rst_ack",   32'(if1.ack), 0);
    chk("rst_busy",  32'(if1.busy), 0);
    chk("rst_gid",   32'(if1.grant_id), 0);
    chk("rst_addr",  32'(if1.musicrom_addr), 0);
    chk("rst_rdata", 32'(if1.rdata), 0);
    rst_n = 1'b1;
    tick();

    // Single request on requester 1, latency 1
    if1.req = 3'b010;
    if1.req_addr[0*RW +: RW] = 17'h1AAAA;
    if1.req_addr[1*RW +: RW] = 17'h00013;
    if1.req_addr[2*RW +: RW] = 17'h05555;
    tick();
    chk("t1_addr", 32'(if1.musicrom_addr), 32'h13);
    chk("t1_busy", 32'(if1.busy), 1);
    chk("t1_gid",  32'(if1.grant_id), 1);
    tick();
    chk("t1_ack_early", 32'(if1.ack), 0);
    tick();
    chk("t1_ack",   32'(if1.ack), 32'b010);
    chk("t1_rdata", 32'(if1.rdata), 32'h05);
    if1.req = 3'b000;
    tick();
    chk("t1_busy_low", 32'(if1.busy), 0);
    chk("t1_ack_low",  32'(if1.ack), 0);

    // All three requesters held from reset
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    if1.req = 3'b111;
    if1.req_addr = {a2, a1, a0};
    for (int g = 0; g < 6; g++) begin
`ifdef MUSICROM_ARB_PRIO0_EN
      exp_id = 3'd0;
`else
      exp_id = 3'(g % 3);
`endif
      tick();
      chk("t2_gid", 32'(if1.grant_id), 32'(exp_id));
      chk("t2_addr", 32'(if1.musicrom_addr),
          32'((exp_id == 0) ? a0 : (exp_id == 1) ? a1 : a2));
      tick(2);
      chk("t2_ack", 32'(if1.ack), 32'(3'b001 << exp_id));
      chk("t2_onehot", 32'($onehot(if1.ack)), 1);
      chk("t2_rdata", 32'(if1.rdata),
          32'(rom_f((exp_id == 0) ? a0 : (exp_id == 1) ? a1 : a2)));
      tick();
    end

    // Requesters 0 and 2 contend, then 0 releases
    if1.req = 3'b101;
    for (int g = 0; g < 3; g++) begin
`ifdef MUSICROM_ARB_PRIO0_EN
      exp_id = 3'd0;
`else
      exp_id = (g == 1) ? 3'd2 : 3'd0;
`endif
      tick();
      chk("t3_gid", 32'(if1.grant_id), 32'(exp_id));
      tick(2);
      chk("t3_ack", 32'(if1.ack), 32'(3'b001 << exp_id));
      chk("t3_rdata", 32'(if1.rdata), 32'(rom_f((exp_id == 0) ? a0 : a2)));
      if (g == 2) if1.req = 3'b100;
      tick();
    end
    tick();
    chk("t3_gid_last", 32'(if1.grant_id), 2);
    tick(2);
    chk("t3_ack_last", 32'(if1.ack), 32'b100);
    if1.req = 3'b000;
    tick();

    // Back-to-back reads, latency 3
    if3.req = 3'b001;
    if3.req_addr[0*RW +: RW] = 17'h10000;
    tick(4);
    chk("t4_ack_early", 32'(if3.ack), 0);
    tick();
    chk("t4_ack0",   32'(if3.ack), 32'b001);
    chk("t4_rdata0", 32'(if3.rdata), 32'h96);
    if3.req_addr[0*RW +: RW] = 17'h10001;
    tick();
    chk("t4_idle_busy", 32'(if3.busy), 0);
    tick();
    chk("t4_addr1", 32'(if3.musicrom_addr), 32'h10001);
    chk("t4_busy1", 32'(if3.busy), 1);
    tick(3);
    chk("t4_ack_mid", 32'(if3.ack), 0);
    tick();
    chk("t4_ack1",   32'(if3.ack), 32'b001);
    chk("t4_rdata1", 32'(if3.rdata), 32'h97);
    if3.req = 3'b000;
    tick();

    // Reset pulsed during WAIT
    if3.req = 3'b010;
    if3.req_addr[1*RW +: RW] = 17'h0ABCD;
    tick(2);
    chk("t5_busy_pre", 32'(if3.busy), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  32'(if3.busy), 0);
    chk("t5_gid",   32'(if3.grant_id), 0);
    chk("t5_addr",  32'(if3.musicrom_addr), 0);
    chk("t5_rdata", 32'(if3.rdata), 0);
    chk("t5_ack",   32'(if3.ack), 0);
    if3.req = 3'b000;
    tick();
    rst_n = 1'b1;
    seen_ack = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      seen_ack = seen_ack | if3.ack;
    end
    chk("t5_no_ack", 32'(seen_ack), 0);
    if3.req = 3'b110;
    if3.req_addr[1*RW +: RW] = 17'h00055;
    if3.req_addr[2*RW +: RW] = 17'h000AA;
    tick();
    chk("t5_gid_after", 32'(if3.grant_id), 1);
    chk("t5_addr_after", 32'(if3.musicrom_addr), 32'h55);
    tick(4);
    chk("t5_ack_after", 32'(if3.ack), 32'b010);
    chk("t5_rdata_after", 32'(if3.rdata), 32'h43);
    if3.req = 3'b000;
    tick();

    // Requester 2 drops req right after grant; requester 1 follows
    if1.req = 3'b100;
    if1.req_addr[2*RW +: RW] = 17'h00077;
    if1.req_addr[1*RW +: RW] = 17'h00033;
    tick();
    chk("t6_gid2", 32'(if1.grant_id), 2);
    if1.req = 3'b010;
    if1.req_addr[2*RW +: RW] = 17'h00000;
    tick(2);
    chk("t6_ack2",   32'(if1.ack), 32'b100);
    chk("t6_rdata2", 32'(if1.rdata), 32'h61);
    tick(2);
    chk("t6_gid1",  32'(if1.grant_id), 1);
    chk("t6_addr1", 32'(if1.musicrom_addr), 32'h33);
    tick(2);
    chk("t6_ack1",   32'(if1.ack), 32'b010);
    chk("t6_rdata1", 32'(if1.rdata), 32'h25);
    if1.req = 3'b000;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
